// File: rtl/wots_base_w_csum.sv
// wots_base_w_csum
// Splits a message digest into base-w digits (MSB first), accumulates the
// WOTS checksum while the message digits stream out, then appends the
// checksum digits. The output is one digit per accepted transfer, tagged with
// its chain index, feeding the WOTS chain controller.
//
// Handshake: digit_valid/digit/digit_idx are decoded from registered state
// only. A transfer happens on a rising edge where digit_valid && digit_ready.
// Once digit_valid is high it stays high, and digit/digit_idx stay stable,
// until that transfer. Nothing on the output side depends combinationally
// on digit_ready.
//
// FSM state is held in state_q (type state_t) so checkers can bind to it
// directly.

module wots_base_w_csum #(
  parameter int WOTS_W     = 16,
  parameter int WOTS_LOG_W = 4,
  parameter int KEY_LEN    = 256,
  parameter int WOTS_LEN1  = 64,
  parameter int WOTS_LEN2  = 3,
  parameter int IDX_W      = 7
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [KEY_LEN-1:0]               msg_in,
  input  logic                             digit_ready,
  output logic                             digit_valid,
  output logic [WOTS_LOG_W-1:0]            digit,
  output logic [IDX_W-1:0]                 digit_idx,
  output logic [WOTS_LEN2*WOTS_LOG_W-1:0]  csum_out,
  output logic                             busy,
  output logic                             done
);

  // Checksum accumulator width: wide enough for WOTS_LEN1*(WOTS_W-1) with
  // the standard parameter choices, and exactly WOTS_LEN2 digits wide, so
  // the checksum digits are simply its nibbles from the top down.
  localparam int CSUM_W = WOTS_LEN2 * WOTS_LOG_W;

  localparam logic [CSUM_W-1:0] DIGIT_MAX    = CSUM_W'(WOTS_W - 1);
  localparam logic [IDX_W-1:0]  LAST_MSG_IDX = IDX_W'(WOTS_LEN1 - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(WOTS_LEN1 + WOTS_LEN2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MSG  = 2'd1,
    ST_CSUM = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // The shift register first holds the message; on the last message
  // transfer it is reloaded with the finished checksum in its top bits, so
  // the same head slice drives the digit output in both phases.
  logic [KEY_LEN-1:0]    shift_q, shift_d;
  logic [CSUM_W-1:0]     csum_q, csum_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  logic                  streaming;
  logic                  xfer;
  logic                  last_msg;
  logic                  last_all;
  logic [WOTS_LOG_W-1:0] head;
  logic [CSUM_W-1:0]     csum_add;

  assign streaming = (state_q == ST_MSG) || (state_q == ST_CSUM);
  assign xfer      = streaming && digit_ready;
  assign last_msg  = (idx_q == LAST_MSG_IDX);
  assign last_all  = (idx_q == LAST_IDX);
  assign head      = shift_q[KEY_LEN-1 -: WOTS_LOG_W];

  // Checksum including the digit being transferred this cycle; on the last
  // message digit this is already the final checksum, so no bubble is needed.
  assign csum_add  = csum_q + DIGIT_MAX
                   - {{(CSUM_W-WOTS_LOG_W){1'b0}}, head};

  // Output decode: all outputs come from registered state only.
  always_comb begin
    digit_valid = streaming;
    busy        = streaming;
    done        = (state_q == ST_DONE);
    digit       = streaming ? head  : '0;
    digit_idx   = streaming ? idx_q : '0;
    csum_out    = csum_q;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: start only counts in IDLE; phases advance on the
  // transfer of their last digit; DONE lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_MSG;
        end
      end
      ST_MSG: begin
        if (xfer && last_msg) begin
          state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (xfer && last_all) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: load on accepted start, shift/count/accumulate on
  // each transfer, hold otherwise (csum is kept through DONE and IDLE).
  always_comb begin
    shift_d = shift_q;
    csum_d  = csum_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d = msg_in;
          csum_d  = '0;
          idx_d   = '0;
        end
      end
      ST_MSG: begin
        if (xfer) begin
          idx_d  = idx_q + IDX_W'(1);
          csum_d = csum_add;
          if (last_msg) begin
            shift_d = {csum_add, {(KEY_LEN-CSUM_W){1'b0}}};
          end else begin
            shift_d = shift_q << WOTS_LOG_W;
          end
        end
      end
      ST_CSUM: begin
        if (xfer) begin
          idx_d   = idx_q + IDX_W'(1);
          shift_d = shift_q << WOTS_LOG_W;
        end
      end
      default: begin
        shift_d = shift_q;
      end
    endcase
  end

  // Datapath registers; reset clears everything, aborting any run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      csum_q  <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      csum_q  <= csum_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_wots_base_w_csum.sv
// Directed bench for wots_base_w_csum: expected digit streams are built from
// the stimulus message plus a hand-computed checksum and held in a queue.

module tb_wots_base_w_csum;

  localparam int KEY_LEN = 256;
  localparam int LOG_W   = 4;
  localparam int IDX_W   = 7;
  localparam int LEN1    = 64;
  localparam int LEN2    = 3;
  localparam int CSUM_W  = LEN2 * LOG_W;
  localparam int DW      = IDX_W + LOG_W;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [KEY_LEN-1:0] msg_in;
  logic               digit_ready;
  logic               digit_valid;
  logic [LOG_W-1:0]   digit;
  logic [IDX_W-1:0]   digit_idx;
  logic [CSUM_W-1:0]  csum_out;
  logic               busy;
  logic               done;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];

  // Clock
  always #5 clk = ~clk;

  wots_base_w_csum dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .msg_in      (msg_in),
    .digit_ready (digit_ready),
    .digit_valid (digit_valid),
    .digit       (digit),
    .digit_idx   (digit_idx),
    .csum_out    (csum_out),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({digit_valid, digit, digit_idx, csum_out, busy, done});
  endfunction

  // Expected stream: message nibbles MSB first, then checksum nibbles.
  task automatic load_expected(input logic [KEY_LEN-1:0] msg, input logic [CSUM_W-1:0] exp_csum);
    exp_q.delete();
    for (int i = 0; i < LEN1; i++) begin
      exp_q.push_back({IDX_W'(i), msg[KEY_LEN-1-LOG_W*i -: LOG_W]});
    end
    for (int j = 0; j < LEN2; j++) begin
      exp_q.push_back({IDX_W'(LEN1+j), exp_csum[CSUM_W-1-LOG_W*j -: LOG_W]});
    end
  endtask

  // One run: start with msg, drive ready, scoreboard every transfer.
  task automatic run_case(input string name, input logic [KEY_LEN-1:0] msg,
                          input logic [CSUM_W-1:0] exp_csum, input bit rand_ready,
                          input bit check_timing, input int abort_idx,
                          input int inject_idx, input bit start_in_done);
    int done_cnt = 0;
    int busy_cnt = 0;
    int done_k = -1;
    bit hold = 1'b0;
    bit finished = 1'b0;
    logic [DW-1:0] held = '0;
    logic [DW-1:0] got;
    logic [DW-1:0] exp;
    load_expected(msg, exp_csum);
    @(negedge clk);
    msg_in = msg;
    start = 1'b1;
    digit_ready = 1'b1;
    for (int k = 1; k <= 600 && !finished; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (hold) begin
        check({name, ":hold_valid"}, 32'(digit_valid), 32'd1);
        check({name, ":hold_data"}, 32'({digit_idx, digit}), 32'(held));
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (start_in_done && done_k > 0 && k == done_k + 1) begin
        check({name, ":start_in_done_ignored"}, 32'({busy, digit_valid}), 32'd0);
      end
      if (abort_idx >= 0 && digit_valid && digit_idx == IDX_W'(abort_idx)) begin
        reset = 1'b0;
        #1;
        check({name, ":async_reset_outputs"}, all_outputs(), 32'd0);
        repeat (3) begin
          @(negedge clk);
          if (done) done_cnt++;
        end
        check({name, ":abort_no_done"}, 32'(done_cnt), 32'd0);
        reset = 1'b1;
        exp_q.delete();
        return;
      end
      if (inject_idx >= 0 && digit_valid && digit_idx == IDX_W'(inject_idx)) begin
        start = 1'b1;
        msg_in = '1;
      end
      if (start_in_done && done) start = 1'b1;
      digit_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      hold = digit_valid && !digit_ready;
      held = {digit_idx, digit};
      if (digit_valid && digit_ready) begin
        if (exp_q.size() == 0) begin
          check({name, ":extra_digit"}, 32'(exp_q.size()), 32'd1);
        end else begin
          got = {digit_idx, digit};
          exp = exp_q.pop_front();
          check({name, ":digit"}, 32'(got), 32'(exp));
        end
      end
      if (done_k > 0 && k >= done_k + 3) finished = 1'b1;
    end
    check({name, ":finished"}, 32'(finished), 32'd1);
    check({name, ":all_digits_seen"}, 32'(exp_q.size()), 32'd0);
    check({name, ":done_once"}, 32'(done_cnt), 32'd1);
    check({name, ":csum_out"}, 32'(csum_out), 32'(exp_csum));
    if (check_timing) begin
      check({name, ":done_latency"}, 32'(done_k), 32'd68);
      check({name, ":busy_cycles"}, 32'(busy_cnt), 32'd67);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    digit_ready = 1'b0;
    msg_in = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), 32'd0);
    reset = 1'b1;

    // All-zero digest: csum = 64*15 = 960 = 0x3C0, start in DONE ignored.
    run_case("zeros", '0, 12'h3C0, 1'b0, 1'b1, -1, -1, 1'b1);
    // All-ones digest: every digit 0xF, csum 0.
    run_case("ones", '1, 12'h000, 1'b0, 1'b0, -1, -1, 1'b0);
    // Ramp 0..F x4: digit sum 480, csum = 960-480 = 480 = 0x1E0.
    run_case("ramp", {4{64'h0123456789abcdef}}, 12'h1E0, 1'b0, 1'b1, -1, -1, 1'b0);
    // Same ramp with random back-pressure.
    run_case("ramp_rand", {4{64'h0123456789abcdef}}, 12'h1E0, 1'b1, 1'b0, -1, -1, 1'b0);
    // Reset pulse at idx 10, then a clean rerun from idx 0.
    run_case("abort", '0, 12'h3C0, 1'b0, 1'b0, 10, -1, 1'b0);
    run_case("after_abort", '0, 12'h3C0, 1'b0, 1'b1, -1, -1, 1'b0);
    // start with all-ones at idx 20 of a zero run is ignored.
    run_case("inject", '0, 12'h3C0, 1'b0, 1'b0, -1, 20, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wots_base_w_csum.md
Name: wots_base_w_csum

Overview:
Upstream stage of gen_chain_with_sha in the WOTS datapath. It takes a KEY_LEN-bit message digest and converts it to WOTS_LEN1 base-w digits. It computes the WOTS checksum and appends the WOTS_LEN2 checksum digits. The resulting digit stream feeds the chain controller, which uses each digit as the step count for one gen_chain_with_sha invocation.

Parameters:
WOTS_W, 16, Winternitz parameter; power of two.
WOTS_LOG_W, 4, log2(WOTS_W); digit width in bits.
KEY_LEN, 256, digest width in bits.
WOTS_LEN1, 64, number of message digits (KEY_LEN/WOTS_LOG_W).
WOTS_LEN2, 3, number of checksum digits.
IDX_W, 7, width of the digit index; must satisfy 2^IDX_W > WOTS_LEN1+WOTS_LEN2.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  single-cycle request; msg_in is sampled with it.
msg_in  in  KEY_LEN  message digest.
digit_ready  in  1  downstream accepts the current digit.
digit_valid  out  1  digit and digit_idx are valid.
digit  out  WOTS_LOG_W  current base-w digit.
digit_idx  out  IDX_W  chain index, 0..WOTS_LEN1+WOTS_LEN2-1.
csum_out  out  WOTS_LEN2*WOTS_LOG_W  final checksum; valid while in CSUM and DONE.
busy  out  1  high from the cycle after start is accepted through the last transfer.
done  out  1  one-cycle pulse after the last digit transfer.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE. All outputs are 0, including the checksum accumulator and the shift register.
- Transfer: occurs on a rising edge with digit_valid && digit_ready.
- Handshake: once digit_valid is asserted, it stays high and digit/digit_idx stay stable until the transfer. There are no combinational paths from digit_ready to digit_valid.
- Digit order: message digits are taken MSB-first. Digit 0 = msg_in[KEY_LEN-1 -: WOTS_LOG_W].
- Shift register: shifts left by WOTS_LOG_W on each transfer.
- Checksum: csum = sum over message digits of (WOTS_W-1-digit).
  - Accumulated on each message-digit transfer, in WOTS_LEN2*WOTS_LOG_W bits.
  - Max value 960 fits in 12 bits for the defaults; no overflow is possible.
  - Checksum digits are csum nibbles, MSB first: idx 64 = csum[11:8], idx 65 = csum[7:4], idx 66 = csum[3:0].
  - This equals the reference left-shift-by-4 and toByte encoding for w=16.
- States and transitions:
  - IDLE: start=1 captures msg_in, clears csum and idx, goes to MSG. start while busy (MSG/CSUM) is ignored.
  - MSG: digit_valid=1. Each transfer increments idx and adds to csum. After the transfer with idx=WOTS_LEN1-1, go to CSUM. The accumulator is final at that edge, so no bubble is inserted.
  - CSUM: digit_valid=1 with digit taken from the csum register. After the transfer with idx=WOTS_LEN1+WOTS_LEN2-1, go to DONE.
  - DONE: digit_valid=0, busy=0, done=1 for exactly one cycle, then IDLE. csum_out is held until the next start.
- Latency: with start high at edge N and digit_ready held high, digits transfer at edges N+1..N+67 and done is high in the cycle following edge N+67. That is 67 cycles of throughput, no bubbles.
- start in the DONE cycle is ignored. start in IDLE is accepted normally.
- Reset mid-operation: everything aborts immediately to the reset values. No done is produced. The next start restarts at idx 0.

Test Plan:
- msg_in=0, ready held high -> 64 digits 0x0, then 3,C,0 (csum=0x3C0=960); done exactly 68 cycles after the start edge; busy high 67 cycles.
- msg_in all ones -> 64 digits 0xF, then 0,0,0; csum_out=0.
- msg_in = {4{64'h0123456789abcdef}} -> digits 0,1,...,F repeated 4 times, then 1,E,0 (csum=480).
- Same vector as the previous scenario with pseudo-random digit_ready (~50% duty) -> identical 67-digit sequence, no drops or duplicates, digit stable while valid&&!ready, done once.
- Pulse reset low while idx=10 -> all outputs 0 asynchronously, no done. A new start with msg_in=0 -> sequence restarts at idx 0 and yields 3,C,0.
- Assert start with msg_in all ones at idx 20 of an all-zero run -> ignored; the run completes with checksum 3,C,0.
